sang_dan: RTL and testbench
===========================

# sang_dan

Progressive LED "fill then drain" sequencer driving an 8-bit LED bank. It lights LEDs one at a time from bit 0 upward until all are on, then turns them off one at a time from the top down, and repeats indefinitely. A built-in prescaler sets the step rate. It is a self-contained leaf block placed directly behind board LED pins. Its only inputs are the clock and reset.

## Interface
- `STEP_CYCLES`, default 1: clock cycles per pattern step; legal range ≥1. Board builds set it to the wanted ms rate; simulation uses 1.
- `N_LED`, default 8: LED count. The output port is fixed at 8 bits, so only 8 is supported.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rs`  in  1  reset; asynchronous, active-low (0 = reset asserted).
- `led`  out  8  LED pattern; bit i high = LED i on. Registered output.

## Operation
- Internal state:
  - prescaler counter `pcnt`, range 0..STEP_CYCLES-1.
  - 4-bit `level`, range 0..8.
  - phase flag: FILL or DRAIN.
- The output is always the thermometer code of `level`: `led = (1<<level)-1`. So level 0 gives 0x00, level 3 gives 0x07, level 8 gives 0xFF.
- `step` is a one-cycle pulse. It fires when `pcnt == STEP_CYCLES-1`; `pcnt` then wraps to 0. Otherwise `pcnt` increments by 1.
- On each `step`:
  - FILL, level < 8: level += 1.
  - FILL, level == 8: phase becomes DRAIN and level becomes 7.
  - DRAIN, level > 0: level -= 1.
  - DRAIN, level == 0: phase becomes FILL and level becomes 1.
- Full cycle is 16 steps, led values in order: 00, 01, 03, 07, 0F, 1F, 3F, 7F, FF, 7F, 3F, 1F, 0F, 07, 03, 01, then back to 00.
- The extremes 0x00 and 0xFF each last exactly one step per cycle; neither is repeated.
- Without a `step`, all of level, phase and led hold their values.

## Timing
- Reset (`rs` = 0) takes effect immediately, without waiting for a clock edge:
  - `led` = 0x00, `level` = 0, phase = FILL, `pcnt` = 0.
- Everything is held in that state while `rs` = 0.
- After `rs` rises, the first `step` occurs on the STEP_CYCLES-th rising edge. `led` changes to 0x01 on that edge.
- With STEP_CYCLES = 1, `led` advances one pattern on every rising edge after reset release.
- Latency from `step` to `led` update is zero extra cycles: `led` is registered on the same edge that the prescaler wraps.
- Reset asserted in mid-sequence (either phase, any `pcnt`) returns to the reset state at once. The sequence restarts from 0x00 with phase FILL.
- Releasing reset coincident with a clock edge: that edge is ignored. Counting starts from the next edge.
- No X on `led` at any time after the first reset assertion.

## Structure
- Package `sang_dan_pkg` holds:
  - constants `LED_W = 8`, `MAX_LEVEL = 8`;
  - phase enum `{PH_FILL, PH_DRAIN}`;
  - function `therm(level)` returning an 8-bit thermometer code.
- Sub-module `sang_dan_tick` is the parameterized prescaler. It takes STEP_CYCLES, `clk` and `rs`, and outputs `step`.
- The top level contains the level/phase FSM and the output register.
- The prescaler counter width is `$clog2(STEP_CYCLES)`, minimum 1 bit.

## Test plan
- Reset held low for 3 clocks -> `led` = 0x00 throughout. Assertion shows 0x00 before the next clock edge.
- STEP_CYCLES = 1, release reset, run 16 clocks -> `led` sequence 01, 03, 07, 0F, 1F, 3F, 7F, FF, 7F, 3F, 1F, 0F, 07, 03, 01, 00.
- Continue 2 more clocks after that -> 01, 03. This confirms the wrap back into FILL without repeating 0x00.
- STEP_CYCLES = 4 -> each pattern holds exactly 4 clocks. First change to 0x01 on the 4th edge after release.
- Reset asserted when `led` = 0x7F during DRAIN, mid-prescale -> `led` = 0x00 immediately. After release it restarts 01, 03…, so FILL phase was restored.
- Run 100 full cycles -> every `led` value has the form 2^k-1. Adjacent values differ by exactly one bit.

Source files
------------

// File: rtl/sang_dan_pkg.sv
// Shared constants, phase encoding and thermometer helper for the LED fill/drain sequencer.
package sang_dan_pkg;
  localparam int LED_W     = 8;
  localparam int MAX_LEVEL = 8;

  typedef enum logic {PH_FILL, PH_DRAIN} phase_t;

  function automatic logic [LED_W-1:0] therm(input logic [3:0] level);
    logic [LED_W-1:0] t;
    for (int i = 0; i < LED_W; i++) t[i] = (int'(level) > i);
    return t;
  endfunction
endpackage

// File: rtl/sang_dan_tick.sv
// Step-rate prescaler: emits step on the last count of every STEP_CYCLES-cycle window.
module sang_dan_tick #(
  parameter int STEP_CYCLES = 1
) (
  input  logic clk,
  input  logic rs,
  output logic step
);
  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] pcnt;

  // Combinational decode so the level register updates on the same edge the counter wraps.
  assign step = (pcnt == LAST);

  always_ff @(posedge clk or negedge rs) begin
    if (!rs)       pcnt <= '0;
    else if (step) pcnt <= '0;
    else           pcnt <= pcnt + CW'(1);
  end
endmodule

// File: rtl/sang_dan.sv
// LED bank sequencer: fills bit 0 upward, drains from the top, repeats forever.
module sang_dan
  import sang_dan_pkg::*;
#(
  parameter int STEP_CYCLES = 1,
  parameter int N_LED       = 8
) (
  input  logic       clk,
  input  logic       rs,
  output logic [7:0] led
);
  // The port is fixed at LED_W bits, so the level never exceeds MAX_LEVEL.
  localparam logic [3:0] TOPLVL = 4'((N_LED < MAX_LEVEL) ? N_LED : MAX_LEVEL);

  logic       step;
  logic [3:0] level, nxt_level;
  phase_t     phase, nxt_phase;

  sang_dan_tick #(.STEP_CYCLES(STEP_CYCLES)) u_tick (
    .clk  (clk),
    .rs   (rs),
    .step (step)
  );

  // Turnaround jumps straight to the neighbour so each extreme is shown for one step only.
  always_comb begin
    nxt_level = level;
    nxt_phase = phase;
    case (phase)
      PH_FILL: begin
        if (level == TOPLVL) begin
          nxt_phase = PH_DRAIN;
          nxt_level = TOPLVL - 4'd1;
        end else begin
          nxt_level = level + 4'd1;
        end
      end
      default: begin
        if (level == 4'd0) begin
          nxt_phase = PH_FILL;
          nxt_level = 4'd1;
        end else begin
          nxt_level = level - 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      level <= 4'd0;
      phase <= PH_FILL;
      led   <= '0;
    end else if (step) begin
      level <= nxt_level;
      phase <= nxt_phase;
      led   <= therm(nxt_level);
    end
  end
endmodule

// File: tb/tb_sang_dan.sv
// Bench for sang_dan at STEP_CYCLES 1 and 4 against a position-in-cycle reference model.
module tb_sang_dan;
  logic       clk = 1'b0;
  logic       rs  = 1'b0;
  logic [7:0] led1, led4;
  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  sang_dan #(.STEP_CYCLES(1), .N_LED(8)) u1 (.clk(clk), .rs(rs), .led(led1));
  sang_dan #(.STEP_CYCLES(4), .N_LED(8)) u4 (.clk(clk), .rs(rs), .led(led4));

  // Expected LED after a number of steps: 16-step triangle wave of lit count.
  function automatic logic [7:0] model(input int steps);
    int pos, lvl;
    logic [8:0] t;
    pos = steps % 16;
    lvl = (pos <= 8) ? pos : 16 - pos;
    t = (9'd1 << lvl) - 9'd1;
    return t[7:0];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rs = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rs = 1'b1;
  endtask

  // Runs len edges after release, comparing both instances to the model.
  task automatic run_check(input string tag, input int len);
    for (int n = 1; n <= len; n++) begin
      @(posedge clk); #1;
      vectors++;
      if (led1 !== model(n)) begin
        errors++;
        $display("FAIL %s s1 edge %0d: got %h want %h", tag, n, led1, model(n));
      end
      vectors++;
      if (led4 !== model(n / 4)) begin
        errors++;
        $display("FAIL %s s4 edge %0d: got %h want %h", tag, n, led4, model(n / 4));
      end
    end
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if (led1 !== 8'h00 || led4 !== 8'h00) begin
      errors++;
      $display("FAIL reset_initial: got %h/%h want 00/00", led1, led4);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (led1 !== 8'h00 || led4 !== 8'h00) begin
        errors++;
        $display("FAIL reset_hold clk %0d: got %h/%h want 00/00", i, led1, led4);
      end
    end
  endtask

  // 18 edges covers the full 16-step cycle plus the wrap back into fill.
  task automatic test_fill_drain();
    release_reset();
    run_check("fill_drain", 18);
  endtask

  task automatic test_mid_reset();
    do_reset();
    release_reset();
    // 37 edges: s4 instance is at 7F in drain with its prescaler part-way through.
    run_check("pre_mid", 37);
    #2 rs = 1'b0;
    #1;
    vectors++;
    if (led1 !== 8'h00 || led4 !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_immediate: got %h/%h want 00/00", led1, led4);
    end
    @(posedge clk); #1;
    vectors++;
    if (led1 !== 8'h00 || led4 !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_hold: got %h/%h want 00/00", led1, led4);
    end
    release_reset();
    run_check("restart", 8);
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int len;
      len = $urandom_range(5, 300);
      do_reset();
      release_reset();
      run_check("random", len);
      #($urandom_range(1, 3)) rs = 1'b0;
      #1;
      vectors++;
      if (led1 !== 8'h00 || led4 !== 8'h00) begin
        errors++;
        $display("FAIL random_reset it %0d: got %h/%h want 00/00", it, led1, led4);
      end
    end
  endtask

  task automatic test_long_run();
    logic [7:0] prev;
    logic [8:0] w;
    do_reset();
    prev = led1;
    release_reset();
    for (int n = 1; n <= 1600; n++) begin
      @(posedge clk); #1;
      w = {1'b0, led1} + 9'd1;
      vectors++;
      if ((w[7:0] & led1) !== 8'h00) begin
        errors++;
        $display("FAIL long_therm edge %0d: got %h not of form 2^k-1", n, led1);
      end
      vectors++;
      if ($countones(led1 ^ prev) != 1) begin
        errors++;
        $display("FAIL long_adjacent edge %0d: got %h after %h want one-bit change", n, led1, prev);
      end
      vectors++;
      if (led4 !== model(n / 4)) begin
        errors++;
        $display("FAIL long_s4 edge %0d: got %h want %h", n, led4, model(n / 4));
      end
      prev = led1;
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_mid_reset();
    test_random();
    test_long_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
